// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Latency: n/a (types only); backpressure: n/a.
package serial_sub_pkg;

    localparam int SS_WIDTH_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_8_fsub_1.sv
// 1-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
// Latency: combinational; backpressure: none.
module fsub_1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_8.sv
// Bit-serial unsigned subtractor, LSB first; optional ovf flag under SERIAL_SUB_OVF_EN.
// Latency: out_valid rises WIDTH cycles after accept; one result per WIDTH+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_sub_8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SS_WIDTH_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_bor;
    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    fsub_1 u_fsub (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_bor),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == BUSY) && (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands shift right so bit 0 always feeds the subtractor; result bits enter at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_bor  <= 1'b0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_diff <= '0;
            r_cnt  <= '0;
            r_bor  <= 1'b0;
        end else if (r_state == BUSY) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_cnt  <= r_cnt + CW'(1);
            r_bor  <= w_bout;
        end
    end

    assign diff   = r_diff;
    assign borrow = r_bor;

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last bit, r_a[0]/r_b[0] are the operand MSBs and w_d is the result MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub_8.sv
// Directed bench for serial_sub_8: handshake timing, results, hold, ignore and reset cases.
`timescale 1ns/1ps
module tb_serial_sub_8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a         = 8'h00;
    logic [7:0] b         = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] diff;
    logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_sub_8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Caller sits #1 after the accepting edge; lat counts edges until out_valid.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                      input logic [7:0] ed, input logic eb);
        int lat;
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(in_ready), 1);
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".busy"}, 32'(in_ready), 0);
        wait_done(lat);
        chk({tag, ".lat"}, 32'(lat), 8);
        chk({tag, ".diff"}, 32'(diff), 32'(ed));
        chk({tag, ".bor"}, 32'(borrow), 32'(eb));
    endtask

    task automatic finish_done(input string tag);
        @(posedge clk); #1;
        chk({tag, ".exit_vld"}, 32'(out_valid), 0);
        chk({tag, ".exit_rdy"}, 32'(in_ready), 1);
    endtask

    logic [7:0] va  [8] = '{8'd100, 8'd37,  8'h80, 8'h00, 8'h7F, 8'h00, 8'hFF, 8'h55};
    logic [7:0] vb  [8] = '{8'd37,  8'd100, 8'h01, 8'h00, 8'h80, 8'h01, 8'hFF, 8'hAA};
    logic [7:0] vd  [8] = '{8'd63,  8'hC1,  8'h7F, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hAB};
    logic       vbr [8] = '{1'b0,   1'b1,   1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
`ifdef SERIAL_SUB_OVF_EN
    logic       vov [8] = '{1'b0,   1'b0,   1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
`endif

    initial begin
        int lat;
        int nres;

        #12;
        chk("rst.vld", 32'(out_valid), 0);
        chk("rst.rdy", 32'(in_ready), 1);
        chk("rst.diff", 32'(diff), 0);
        chk("rst.bor", 32'(borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            op($sformatf("v%0d", i), va[i], vb[i], vd[i], vbr[i]);
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("v%0d.ovf", i), 32'(ovf), 32'(vov[i]));
`endif
            finish_done($sformatf("v%0d", i));
        end

        // Result held under backpressure while inputs churn.
        out_ready = 1'b0;
        op("hold", 8'd200, 8'd50, 8'd150, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a = 8'(k * 37 + 1);
            b = 8'(k * 91 + 5);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold.vld", 32'(out_valid), 1);
            chk("hold.rdy", 32'(in_ready), 0);
            chk("hold.diff", 32'(diff), 150);
            chk("hold.bor", 32'(borrow), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        finish_done("hold");

        // in_valid toggling during BUSY must be ignored.
        @(negedge clk);
        a = 8'd10;
        b = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 8'hFF;
            b = 8'hFF;
            in_valid = (k % 2 == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        chk("glitch.lat", 32'(lat), 5);
        chk("glitch.diff", 32'(diff), 7);
        chk("glitch.bor", 32'(borrow), 0);
        nres = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid) nres++;
        end
        chk("glitch.once", 32'(nres), 0);

        // Reset in the middle of BUSY abandons the operation.
        @(negedge clk);
        a = 8'h55;
        b = 8'h22;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid.partial", 32'(diff), 32'h30);
        rst_n = 1'b0;
        #1;
        chk("arst.vld", 32'(out_valid), 0);
        chk("arst.rdy", 32'(in_ready), 1);
        chk("arst.diff", 32'(diff), 0);
        chk("arst.bor", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("arst.ovf", 32'(ovf), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        nres = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid) nres++;
        end
        chk("arst.noresult", 32'(nres), 0);

        // First edge after reset release accepts.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'd9;
        b = 8'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first.acc", 32'(in_ready), 0);
        wait_done(lat);
        chk("first.lat", 32'(lat), 8);
        chk("first.diff", 32'(diff), 5);
        finish_done("first");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
